// File: rtl/uart_pkg.sv
// Shared UART types: transmitter FSM states, character-width encodings and width decode.
// Imported by the transmitter top and its shift-register datapath.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_CTS_WAIT = 3'd1,
      ST_START    = 3'd2,
      ST_DATA     = 3'd3,
      ST_PARITY   = 3'd4,
      ST_STOP     = 3'd5,
      ST_FINISH   = 3'd6,
      ST_SPARE    = 3'd7
   } tx_state_t;

   localparam logic [1:0] WIDTH_5 = 2'd0;
   localparam logic [1:0] WIDTH_6 = 2'd1;
   localparam logic [1:0] WIDTH_7 = 2'd2;
   localparam logic [1:0] WIDTH_8 = 2'd3;

   function automatic logic [3:0] data_bits(input logic [1:0] width);
      return 4'd5 + {2'b00, width};
   endfunction

endpackage

// File: rtl/tx_shift_register.sv
// Character shifter for the UART transmitter: bit0 is presented after load, each shift exposes the next bit.
// Tracks the index of the bit on the line and the parity of all bits already emitted.
module tx_shift_register
   import uart_pkg::*;
#(
   parameter int DATA_MAX = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                load_i,
   input  logic                shift_i,
   input  logic [DATA_MAX-1:0] data_i,
   input  logic [1:0]          width_i,
   output logic                bit_o,
   output logic                next_bit_o,
   output logic                last_bit_o,
   output logic                parity_o
);

   logic [DATA_MAX-1:0] shift_q, shift_d;
   logic [2:0]          count_q, count_d;
   logic                par_q,   par_d;

   always_comb begin
      shift_d = shift_q;
      count_d = count_q;
      par_d   = par_q;
      if (load_i) begin
         shift_d = data_i;
         count_d = 3'd0;
         par_d   = 1'b0;
      end else if (shift_i) begin
         shift_d = shift_q >> 1;
         count_d = count_q + 3'd1;
         par_d   = par_q ^ shift_q[0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shift_q <= '0;
         count_q <= 3'd0;
         par_q   <= 1'b0;
      end else begin
         shift_q <= shift_d;
         count_q <= count_d;
         par_q   <= par_d;
      end
   end

   assign bit_o      = shift_q[0];
   assign next_bit_o = shift_q[1];
   assign last_bit_o = ({1'b0, count_q} == (data_bits(width_i) - 4'd1));
   // The bit currently on the line has not been folded into par_q yet.
   assign parity_o   = par_q ^ shift_q[0];

endmodule

// File: rtl/uart_transmitter.sv
// UART transmit framer: start, 5-8 data bits LSB first, optional parity, 1-2 stop bits, paced by clk_1x_i.
// Accepts one character per valid/ready handshake in IDLE only; waits for cts_ni low before the start bit.
module uart_transmitter
   import uart_pkg::*;
#(
   parameter int DATA_MAX = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                tx_en_i,
   input  logic                clk_1x_i,
   input  logic                cts_ni,
   input  logic [DATA_MAX-1:0] data_i,
   input  logic                data_valid_i,
   output logic                data_ready_o,
   input  logic [1:0]          data_width_i,
   input  logic                parity_en_i,
   input  logic                parity_odd_i,
   input  logic                stop2_i,
   output logic                tx_o,
   output logic                tx_busy_o,
   output logic                tx_done_o
);

   tx_state_t  state_q, state_d;
   logic       tx_q, tx_d;
   logic       stop_cnt_q, stop_cnt_d;
   logic [1:0] width_q, width_d;
   logic       par_en_q, par_en_d;
   logic       par_odd_q, par_odd_d;
   logic       stop2_q, stop2_d;

   logic       load;
   logic       shift;
   logic       sr_bit;
   logic       sr_next_bit;
   logic       sr_last;
   logic       sr_parity;

   tx_shift_register #(
      .DATA_MAX (DATA_MAX)
   ) u_shift (
      .clk        (clk),
      .reset      (reset),
      .load_i     (load),
      .shift_i    (shift),
      .data_i     (data_i),
      .width_i    (width_q),
      .bit_o      (sr_bit),
      .next_bit_o (sr_next_bit),
      .last_bit_o (sr_last),
      .parity_o   (sr_parity)
   );

   assign data_ready_o = (state_q == ST_IDLE) && tx_en_i && !reset;
   assign tx_busy_o    = (state_q != ST_IDLE);
   assign tx_done_o    = (state_q == ST_FINISH);
   assign tx_o         = tx_q;

   always_comb begin
      state_d    = state_q;
      tx_d       = tx_q;
      stop_cnt_d = stop_cnt_q;
      width_d    = width_q;
      par_en_d   = par_en_q;
      par_odd_d  = par_odd_q;
      stop2_d    = stop2_q;
      load       = 1'b0;
      shift      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            tx_d       = 1'b1;
            stop_cnt_d = 1'b0;
            if (data_valid_i && data_ready_o) begin
               load      = 1'b1;
               width_d   = data_width_i;
               par_en_d  = parity_en_i;
               par_odd_d = parity_odd_i;
               stop2_d   = stop2_i;
               state_d   = ST_CTS_WAIT;
            end
         end
         ST_CTS_WAIT: begin
            tx_d = 1'b1;
            if (!tx_en_i) begin
               state_d = ST_IDLE;
            end else if (clk_1x_i && !cts_ni) begin
               tx_d    = 1'b0;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (clk_1x_i) begin
               tx_d    = sr_bit;
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (clk_1x_i) begin
               if (sr_last) begin
                  if (par_en_q) begin
                     tx_d    = sr_parity ^ par_odd_q;
                     state_d = ST_PARITY;
                  end else begin
                     tx_d    = 1'b1;
                     state_d = ST_STOP;
                  end
               end else begin
                  shift = 1'b1;
                  tx_d  = sr_next_bit;
               end
            end
         end
         ST_PARITY: begin
            if (clk_1x_i) begin
               tx_d    = 1'b1;
               state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            tx_d = 1'b1;
            if (clk_1x_i) begin
               // First of two stop periods just ended; stay for the second.
               if (stop2_q && !stop_cnt_q) begin
                  stop_cnt_d = 1'b1;
               end else begin
                  stop_cnt_d = 1'b0;
                  state_d    = ST_FINISH;
               end
            end
         end
         ST_FINISH: begin
            tx_d    = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            tx_d       = 1'b1;
            stop_cnt_d = 1'b0;
            state_d    = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         tx_q       <= 1'b1;
         stop_cnt_q <= 1'b0;
         width_q    <= WIDTH_8;
         par_en_q   <= 1'b0;
         par_odd_q  <= 1'b0;
         stop2_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         tx_q       <= tx_d;
         stop_cnt_q <= stop_cnt_d;
         width_q    <= width_d;
         par_en_q   <= par_en_d;
         par_odd_q  <= par_odd_d;
         stop2_q    <= stop2_d;
      end
   end

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

- Serialises one parallel character per valid/ready handshake into an asynchronous UART frame: start bit, 5–8 data bits LSB first, optional parity, then 1 or 2 stop bits.
- Paces every bit from the shared one-cycle baud tick and honours the active-low clear-to-send input before starting a frame.
- Is the transmit-side counterpart of the receiver controller in the APB UART. It sits between the APB register/TX-FIFO side and the serial TX pin.

## Interface
Parameters:
- DATA_MAX, 8, width of the data input bus (max character length).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- tx_en_i  input  1  transmitter enable.
- clk_1x_i  input  1  baud tick, one clk cycle high per bit period.
- cts_ni  input  1  clear-to-send, active low.
- data_i  input  DATA_MAX  character to send.
- data_valid_i  input  1  data_i valid.
- data_ready_o  output  1  block can accept a character.
- data_width_i  input  2  character length: 0=5, 1=6, 2=7, 3=8 bits.
- parity_en_i  input  1  append a parity bit.
- parity_odd_i  input  1  1=odd parity, 0=even parity.
- stop2_i  input  1  1=two stop bits, 0=one stop bit.
- tx_o  output  1  serial line; registered; idles high.
- tx_busy_o  output  1  high in every state except IDLE.
- tx_done_o  output  1  one-cycle pulse when the final stop bit completes.

## Operation
- States:
  - IDLE: tx_o=1. data_ready_o = tx_en_i (combinational), forced 0 while reset is high. When data_valid_i & data_ready_o, the block latches the character, data_width_i, parity_en_i, parity_odd_i and stop2_i, then moves to CTS_WAIT.
  - CTS_WAIT: tx_o=1.
    - tx_en_i low → IDLE. The latched character is discarded and tx_done_o does not pulse.
    - Otherwise, on clk_1x_i with cts_ni low → START, and tx_o←0.
  - START: on clk_1x_i → DATA, and tx_o←bit0.
  - DATA: on each clk_1x_i, shift out the next bit. After the last bit (index N-1, where N = 5 + latched width):
    - → PARITY with tx_o←parity bit, if parity is enabled;
    - otherwise → STOP with tx_o←1.
  - PARITY: on clk_1x_i → STOP, and tx_o←1.
  - STOP: holds tx_o=1 for 1 or 2 tick periods (from stop2). On the final tick → FINISH.
  - FINISH: one cycle. tx_done_o=1, then → IDLE.
- Parity bit = XOR of the N transmitted bits, inverted when odd. Bits of data_i above N-1 are ignored.
- Configuration changes after the handshake do not affect the frame in flight.
- Deasserting tx_en_i after START: the frame completes normally.
- Changes on cts_ni after START: ignored.
- A clk_1x_i pulse in IDLE or FINISH has no effect.

## Timing
- Reset values:
  - state IDLE
  - tx_o=1
  - tx_busy_o=0
  - tx_done_o=0
  - data_ready_o=0
  - bit counter and stop counter 0
- A reset assertion mid-frame returns tx_o to 1 immediately (asynchronous); the frame is lost.
- Handshake accepted at edge E. tx_busy_o is high from E+1.
- Start bit begins at the first edge T after E where clk_1x_i=1 and cts_ni=0.
- Frame length is exactly (1 + N + P + S) tick periods from T, where P∈{0,1} is parity and S∈{1,2} is stop bits.
- tx_done_o is high the cycle after the final stop tick. data_ready_o returns one cycle after that.
- Back-to-back characters: minimum gap between stop end and the next start bit is the wait for the next clk_1x_i after re-acceptance. No extra idle bit is inserted.

## Structure
- Shared package uart_pkg:
  - tx_state_t enum (8 states, 3 bits);
  - width encoding constants (WIDTH_5..WIDTH_8);
  - function data_bits(width) returning 5–8.
- Sub-module tx_shift_register:
  - load, shift-on-tick and a 3-bit count;
  - raises last_bit_o when the count equals N-1;
  - computes the running parity.
- uart_transmitter holds the FSM, stop counter, latched configuration and the tx_o register.

## Test plan
- 8N1, data 0xA5, cts_ni=0, tick every 16 clk:
  - tx_o = 0,1,0,1,0,0,1,0,1,1, each 16 cycles;
  - tx_done_o pulses once;
  - tx_busy_o spans 10 bit periods.
- 7-bit, even parity, 2 stop bits, data 0x3D:
  - bits 1,0,1,1,1,1,0;
  - parity 1;
  - stop 1,1;
  - total 11 tick periods.
- 5-bit, odd parity, data 0x1F: bits 1,1,1,1,1, parity 0, one stop bit.
- CTS held high for 5 ticks after the handshake, then low:
  - tx_o stays 1 throughout the wait;
  - the start bit begins on the first tick with cts_ni=0.
- tx_en_i dropped in CTS_WAIT:
  - → IDLE, tx_o never goes low, no tx_done_o.
- Reset pulsed during the DATA state of 0xFF, then a new 0x00 8N1 frame:
  - tx_o=1 and tx_busy_o=0 immediately on reset;
  - the second frame is transmitted correctly.
